// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM states and the queued command.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StMstart,
    StMwait,
    StResp
  } issuer_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } alu_cmd_t;

  localparam int unsigned CmdWidth = $bits(alu_cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding queued ALU commands; one extra pointer bit separates full from empty.
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = CmdWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Serialises queued commands onto alu32, launches MOD with a start pulse and returns each
// result (or a MOD timeout) on a valid/ready response channel.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned Timeout = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  input  logic [2:0]  cmd_op_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_start_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_out_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [2:0]  rsp_op_o,
  output logic        rsp_timeout_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(Timeout) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);
  localparam logic [CntW-1:0] CntOne  = 1;

  issuer_state_e   state_q, state_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [2:0]      rsp_op_q, rsp_op_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  alu_cmd_t push_cmd, head_cmd;
  logic     fifo_full, fifo_empty, fifo_pop;

  assign push_cmd = '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};

  cmd_fifo #(
    .Depth (Depth),
    .Width (CmdWidth)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    rsp_data_d    = rsp_data_q;
    rsp_op_d      = rsp_op_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_a_d  = head_cmd.a;
          alu_b_d  = head_cmd.b;
          alu_op_d = head_cmd.op;
          state_d  = (head_cmd.op == OP_MOD) ? StMstart : StDrive;
        end
      end
      // Single-cycle ops settle combinationally in alu32 once operands are registered.
      StDrive: begin
        rsp_data_d    = alu_out_i;
        rsp_op_d      = alu_op_q;
        rsp_timeout_d = 1'b0;
        state_d       = StResp;
      end
      StMstart: begin
        cnt_d   = '0;
        state_d = StMwait;
      end
      StMwait: begin
        cnt_d = cnt_q + CntOne;
        // A done arriving on the final timeout cycle still delivers the real result.
        if (alu_done_i) begin
          rsp_data_d    = alu_out_i;
          rsp_op_d      = alu_op_q;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (cnt_q == CntLast) begin
          rsp_data_d    = '0;
          rsp_op_d      = alu_op_q;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      rsp_data_q    <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      rsp_data_q    <= rsp_data_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready_o   = !fifo_full;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign alu_start_o   = (state_q == StMstart);
  assign rsp_valid_o   = (state_q == StResp);
  assign rsp_data_o    = rsp_data_q;
  assign rsp_op_o      = rsp_op_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural alu32 stand-in and a queue model.
module tb_alu_cmd_issuer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  localparam logic [2:0] L_AND = 3'b000;
  localparam logic [2:0] L_OR  = 3'b001;
  localparam logic [2:0] L_XOR = 3'b010;
  localparam logic [2:0] L_NOR = 3'b011;
  localparam logic [2:0] L_SLT = 3'b100;
  localparam logic [2:0] L_ADD = 3'b101;
  localparam logic [2:0] L_SUB = 3'b110;
  localparam logic [2:0] L_MOD = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_start, alu_done;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_op;

  int tests = 0;
  int fails = 0;

  // ALU stand-in controls: fixed done delay (0 = never) or operand-derived delay in random mode
  int done_delay = 0;
  bit rand_mode  = 1'b0;
  bit stray_done = 1'b0;
  int dcnt       = 0;
  int cur_delay  = 0;
  int start_cnt  = 0;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  op;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .Depth   (DEPTH),
    .Timeout (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_a_i       (cmd_a),
    .cmd_b_i       (cmd_b),
    .cmd_op_i      (cmd_op),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_op_o      (alu_op),
    .alu_start_o   (alu_start),
    .alu_done_i    (alu_done),
    .alu_out_i     (alu_out),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_op_o      (rsp_op),
    .rsp_timeout_o (rsp_timeout),
    .busy_o        (busy)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101:  return a + b;
      3'b110:  return a - b;
      default: return (b == 32'd0) ? 32'd0 : a % b;
    endcase
  endfunction

  assign alu_out  = ref_alu(alu_a, alu_b, alu_op);
  assign alu_done = stray_done || (cur_delay != 0 && dcnt == cur_delay);

  always @(posedge clk) begin
    if (alu_start) begin
      start_cnt <= start_cnt + 1;
      dcnt      <= 1;
      cur_delay <= rand_mode ? ((alu_a[4:0] == 5'd0) ? 0 : int'(alu_a[4:0])) : done_delay;
    end else if (dcnt != 0) begin
      dcnt <= dcnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit ok = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL push_accept: cmd_ready stayed %0b, required 1 within 500 cycles", cmd_ready);
    end
  endtask

  task automatic wait_rsp(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    #12;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready);
    end
    tests++;
    if ({alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_data, rsp_op, rsp_timeout, busy} !== '0)
    begin
      fails++;
      $display("FAIL reset_outputs: alu_a=%h alu_op=%h start=%b rsp_valid=%b data=%h busy=%b, required all 0",
               alu_a, alu_op, alu_start, rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int s0 = start_cnt;
    rsp_ready = 1'b1;
    push(32'd5, 32'd7, L_ADD);           // now in cycle t+1
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL add_t1: rsp_valid=%b busy=%b, required 0/1", rsp_valid, busy);
    end
    step();                               // t+2
    tests++;
    if (alu_op !== L_ADD || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_t2: alu_op=%b rsp_valid=%b, required 101/0", alu_op, rsp_valid);
    end
    step();                               // t+3
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_op !== L_ADD || rsp_timeout !== 1'b0)
    begin
      fails++;
      $display("FAIL add_rsp: valid=%b data=%0d op=%b to=%b, required 1/12/101/0",
               rsp_valid, rsp_data, rsp_op, rsp_timeout);
    end
    step();
    tests++;
    if (rsp_valid !== 1'b0 || start_cnt != s0) begin
      fails++;
      $display("FAIL add_after: rsp_valid=%b starts=%0d, required 0/0", rsp_valid, start_cnt - s0);
    end
  endtask

  task automatic test_mod();
    int  s0 = start_cnt;
    int  si = -1;
    int  ri = -1;
    bit  stable = 1'b1;
    logic [31:0] d = '0;
    logic [2:0]  o = '0;
    logic        to = 1'b0;
    done_delay = 10;
    rsp_ready  = 1'b1;
    push(32'd17, 32'd5, L_MOD);
    step();                               // operands now loaded
    for (int i = 0; i < 100; i++) begin
      if (alu_a !== 32'd17 || alu_b !== 32'd5 || alu_op !== L_MOD) stable = 1'b0;
      if (alu_start && si < 0) si = i;
      if (rsp_valid) begin
        ri = i; d = rsp_data; o = rsp_op; to = rsp_timeout;
        break;
      end
      step();
    end
    tests++;
    if (ri < 0 || si < 0 || ri - si != 11) begin
      fails++; $display("FAIL mod_latency: start@%0d rsp@%0d, required rsp 11 after start", si, ri);
    end
    tests++;
    if (start_cnt - s0 != 1 || !stable) begin
      fails++;
      $display("FAIL mod_start: pulses=%0d stable=%0b, required 1/1", start_cnt - s0, stable);
    end
    tests++;
    if (d !== 32'd2 || o !== L_MOD || to !== 1'b0) begin
      fails++; $display("FAIL mod_rsp: data=%0d op=%b to=%b, required 2/111/0", d, o, to);
    end
    step();
  endtask

  task automatic test_timeout();
    int s0 = start_cnt;
    int si = -1;
    int ri = -1;
    bit got;
    logic [31:0] d = 32'hdead;
    logic        to = 1'b0;
    done_delay = 0;
    rsp_ready  = 1'b1;
    push(32'd100, 32'd7, L_MOD);
    push(32'h0000F0F0, 32'h0000FF00, L_AND);
    for (int i = 0; i < 200; i++) begin
      if (alu_start && si < 0) si = i;
      if (rsp_valid) begin
        ri = i; d = rsp_data; to = rsp_timeout;
        break;
      end
      step();
    end
    tests++;
    if (ri < 0 || si < 0 || ri - si != TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout_latency: start@%0d rsp@%0d, required rsp %0d after start",
               si, ri, TIMEOUT + 1);
    end
    tests++;
    if (d !== 32'd0 || to !== 1'b1 || start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL timeout_rsp: data=%h to=%b pulses=%0d, required 0/1/1", d, to,
               start_cnt - s0);
    end
    step();
    wait_rsp(20, got);
    tests++;
    if (!got || rsp_data !== 32'h0000F000 || rsp_op !== L_AND || rsp_timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_next: got=%b data=%h op=%b to=%b, required 1/0000f000/000/0",
               got, rsp_data, rsp_op, rsp_timeout);
    end
    step();
  endtask

  task automatic test_fill();
    logic [31:0] exp_d[5];
    logic [31:0] got_d[5];
    int          idx[5];
    int          n = 0;
    bit          stalled_ok = 1'b1;
    exp_d[0] = 32'd5; exp_d[1] = 32'h30; exp_d[2] = 32'h33; exp_d[3] = 32'hF0;
    exp_d[4] = 32'hFF000000;
    rsp_ready = 1'b0;
    push(32'd9, 32'd4, L_SUB);
    push(32'hF0, 32'h3C, L_AND);
    push(32'h12, 32'h21, L_OR);
    push(32'hFF, 32'h0F, L_XOR);
    push(32'h0000FFFF, 32'h00FF0000, L_NOR);
    tests++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL fill_full: cmd_ready=%b busy=%b rsp_valid=%b, required 0/1/1",
               cmd_ready, busy, rsp_valid);
    end
    cmd_a = 32'd1; cmd_b = 32'd1; cmd_op = L_ADD; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready !== 1'b0) stalled_ok = 1'b0;
      step();
    end
    cmd_valid = 1'b0;
    tests++;
    if (!stalled_ok) begin
      fails++; $display("FAIL fill_stall: cmd_ready rose while full, required 0");
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) begin
        if (n < 5) begin
          got_d[n] = rsp_data; idx[n] = i;
        end
        n++;
      end
      step();
    end
    tests++;
    if (n != 5) begin
      fails++; $display("FAIL fill_count: %0d responses, required 5", n);
    end
    for (int k = 0; k < 5 && k < n; k++) begin
      tests++;
      if (got_d[k] !== exp_d[k]) begin
        fails++; $display("FAIL fill_order[%0d]: data=%h, required %h", k, got_d[k], exp_d[k]);
      end
    end
    if (n == 5) begin
      tests++;
      if (idx[4] - idx[1] != 9) begin
        fails++;
        $display("FAIL fill_throughput: 3 gaps span %0d cycles, required 9", idx[4] - idx[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bit got;
    done_delay = 0;
    rsp_ready  = 1'b1;
    push(32'd50, 32'd3, L_MOD);
    push(32'd1, 32'd1, L_AND);
    for (int i = 0; i < 10 && !alu_start; i++) step();
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1 ||
        {alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_data, rsp_op, rsp_timeout, busy} !== '0)
    begin
      fails++;
      $display("FAIL midreset_async: cmd_ready=%b alu_a=%h alu_op=%b busy=%b, required 1/0/0/0",
               cmd_ready, alu_a, alu_op, busy);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid || busy || alu_start) seen = 1'b1;
      step();
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL midreset_silent: activity after reset, required none");
    end
    push(32'hFFFFFFFF, 32'd1, L_SLT);
    wait_rsp(20, got);
    tests++;
    if (!got || rsp_data !== 32'd1 || rsp_op !== L_SLT) begin
      fails++;
      $display("FAIL midreset_slt: got=%b data=%h op=%b, required 1/1/100", got, rsp_data, rsp_op);
    end
    step();
  endtask

  task automatic test_stray_done();
    bit got;
    rsp_ready  = 1'b1;
    stray_done = 1'b1;
    step(); step();
    stray_done = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL stray_idle: rsp_valid=%b busy=%b, required 0/0", rsp_valid, busy);
    end
    push(32'hFFFF0000, 32'h0F0F0F0F, L_XOR);
    wait_rsp(20, got);
    tests++;
    if (!got || rsp_data !== 32'hF0F00F0F || rsp_op !== L_XOR || rsp_timeout !== 1'b0) begin
      fails++;
      $display("FAIL stray_xor: got=%b data=%h op=%b, required 1/f0f00f0f/010", got, rsp_data,
               rsp_op);
    end
    step();
  endtask

  task automatic test_random();
    localparam int N = 40;
    rand_mode = 1'b1;
    exp_q.delete();
    fork
      begin : producer
        for (int i = 0; i < N; i++) begin
          logic [31:0] a = $urandom;
          logic [31:0] b = $urandom;
          logic [2:0]  op = 3'($urandom_range(0, 7));
          exp_t e;
          int gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) step();
          if (op == L_MOD) b = 32'($urandom_range(1, 1000));
          // In random mode the ALU answers MOD after a[4:0] cycles; a[4:0]==0 never answers.
          if (op == L_MOD && a[4:0] == 5'd0) begin
            e.d = '0; e.op = op; e.to = 1'b1;
          end else begin
            e.d = ref_alu(a, b, op); e.op = op; e.to = 1'b0;
          end
          push(a, b, op);
          exp_q.push_back(e);
        end
      end
      begin : consumer
        int got = 0;
        for (int c = 0; c < 20000 && got < N; c++) begin
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL rand_extra: data=%h with no command outstanding", rsp_data);
            end else begin
              exp_t e = exp_q.pop_front();
              if (rsp_data !== e.d || rsp_op !== e.op || rsp_timeout !== e.to) begin
                fails++;
                $display("FAIL rand_rsp[%0d]: data=%h op=%b to=%b, required %h/%b/%b", got,
                         rsp_data, rsp_op, rsp_timeout, e.d, e.op, e.to);
              end
            end
            got++;
          end
          step();
        end
        tests++;
        if (got != N) begin
          fails++; $display("FAIL rand_count: %0d responses, required %0d", got, N);
        end
      end
    join
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mod();
    test_timeout();
    test_fill();
    test_reset_mid();
    test_stray_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
